// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding
// (state = owner of the previous cycle) and port indices.
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arbState_t;

  localparam int PORT_CPU  = 0;
  localparam int PORT_DMA  = 1;
  localparam int NUM_PORTS = 2;
  localparam int DATA_W    = 32;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data_memory.
//   req_*      : per-port request (bit / suffix n = port n)
//   req_ready  : one-hot grant back to the requesters
//   rsp_*      : one-cycle read response, shared data bus
//   mem_*      : drive to / read data from data_memory
// slave  modport : arbiter side
// master modport : requesters + memory side
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 7
);
  import data_memory_arbiter_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [31:0]       mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_write;
  logic              mem_read;

  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_address, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_address, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/data_memory_arbiter_pick.sv
// Pure combinational 2-way grant select.
//   state     : owner of the previous cycle
//   reqValid  : per-port request valid
//   lastOwner : port granted most recently (breaks ties from IDLE)
//   burstHit  : current owner has used up its burst while the other waits
//   grant     : one-hot grant (00 = none)
module dm_arb_pick
  import data_memory_arbiter_pkg::*;
(
  input  arbState_t  state,
  input  logic [1:0] reqValid,
  input  logic       lastOwner,
  input  logic       burstHit,
  output logic [1:0] grant
);
  logic own;
  assign own = (state == ST_OWN1);

  always_comb begin
    grant = '0;
    case (state)
      ST_OWN0, ST_OWN1: begin
        // Owner keeps the port unless the other side is waiting and the burst is spent.
        if (reqValid[own] && (!reqValid[~own] || !burstHit)) grant[own]  = 1'b1;
        else if (reqValid[~own])                              grant[~own] = 1'b1;
      end
      default: begin
        if (&reqValid) grant[~lastOwner] = 1'b1;
        else           grant             = reqValid;
      end
    endcase
  end
endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter with burst cap sharing the single-port 128x32 data
// memory between port 0 (CPU MEM stage) and port 1 (DMA/debug loader).
//   clock_in : clock, all state on posedge
//   reset_n  : synchronous active-low reset
//   bus      : request/response/memory bundle (slave side)
// Reads have one cycle of latency: rsp_data/rsp_valid are registered at the
// edge that ends the grant cycle. Writes produce no response.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int MAX_BURST = 4
) (
  input logic                  clock_in,
  input logic                  reset_n,
  data_memory_arbiter_if.slave bus
);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  arbState_t              state, stateNxt;
  logic                   lastOwner;
  logic [CNT_W-1:0]       burstCnt, burstNxt;
  logic [1:0]             rspValidQ;
  logic [DATA_W-1:0]      rspDataQ;
  logic [1:0]             pickGrant, grant;
  logic                   gPort, anyGrant, burstHit;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;

  assign addr  = {bus.req_addr1, bus.req_addr0};
  assign wdata = {bus.req_wdata1, bus.req_wdata0};

  assign burstHit = (burstCnt == CNT_MAX);

  dm_arb_pick uPick (
    .state     (state),
    .reqValid  (bus.req_valid),
    .lastOwner (lastOwner),
    .burstHit  (burstHit),
    .grant     (pickGrant)
  );

  // No grant (and hence no memory write) while reset is held.
  assign grant    = reset_n ? pickGrant : 2'b00;
  assign anyGrant = |grant;
  assign gPort    = grant[1];

  always_comb begin
    stateNxt = ST_IDLE;
    burstNxt = '0;
    if (anyGrant) begin
      stateNxt = gPort ? ST_OWN1 : ST_OWN0;
      // Count only kept grants; any owner change (incl. from IDLE) restarts at 0.
      if (state == stateNxt) burstNxt = burstHit ? burstCnt : burstCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      lastOwner <= 1'b1;
      burstCnt  <= '0;
      rspValidQ <= '0;
      rspDataQ  <= '0;
    end else begin
      state     <= stateNxt;
      burstCnt  <= burstNxt;
      rspValidQ <= grant & ~bus.req_write;
      if (anyGrant) lastOwner <= gPort;
      if (anyGrant && !bus.req_write[gPort]) rspDataQ <= bus.mem_rdata;
    end
  end

  assign bus.req_ready   = grant;
  // A response registered just before reset asserts is suppressed.
  assign bus.rsp_valid   = reset_n ? rspValidQ : 2'b00;
  assign bus.rsp_data    = rspDataQ;
  assign bus.mem_address = anyGrant ? 32'(addr[gPort]) : 32'd0;
  assign bus.mem_wdata   = anyGrant ? wdata[gPort] : '0;
  assign bus.mem_write   = anyGrant &  bus.req_write[gPort];
  assign bus.mem_read    = anyGrant & ~bus.req_write[gPort];
endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  data_memory_arbiter_if #(.ADDR_W(7)) bus();

  data_memory_arbiter #(.ADDR_W(7), .MAX_BURST(MAX_BURST)) dut (
    .clock_in (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  // Behavioural data_memory: writes on negedge, combinational read.
  logic [31:0] mem [128];
  always @(negedge clk) if (bus.mem_write) mem[bus.mem_address[6:0]] <= bus.mem_wdata;
  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_address[6:0]] : 32'd0;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 none), length of current run, last granted port,
  // expected memory contents and the response due next cycle.
  int          owner, run, lastOwn;
  logic [31:0] refMem [128];
  logic [1:0]  expRspV;
  logic [31:0] expRspD;
  logic [1:0]  seenReady;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    owner = -1; run = 0; lastOwn = 1; expRspV = 2'b00; expRspD = 32'd0;
  endtask

  // One clock cycle: drive at posedge+1, check mid-cycle, advance the model.
  task automatic cyc(input logic rst, input logic [1:0] v, input logic [1:0] w,
                     input logic [6:0] a0, input logic [6:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1);
    int g, oth;
    logic [6:0]  ga;
    logic [31:0] gd;
    reset_n = rst;
    bus.req_valid = v; bus.req_write = w;
    bus.req_addr0 = a0; bus.req_addr1 = a1;
    bus.req_wdata0 = d0; bus.req_wdata1 = d1;
    #2;
    g = -1;
    if (rst) begin
      if (owner < 0) begin
        if (v == 2'b11) g = 1 - lastOwn;
        else if (v[0])  g = 0;
        else if (v[1])  g = 1;
      end else begin
        oth = 1 - owner;
        if (v[owner] && (!v[oth] || run < MAX_BURST)) g = owner;
        else if (v[oth]) g = oth;
      end
    end
    ga = (g == 1) ? a1 : a0;
    gd = (g == 1) ? d1 : d0;
    seenReady = bus.req_ready;
    chk("req_ready", {30'd0, bus.req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
    chk("mem_write", {31'd0, bus.mem_write}, {31'd0, (g >= 0) && w[g]});
    chk("mem_read",  {31'd0, bus.mem_read},  {31'd0, (g >= 0) && !w[g]});
    chk("mem_address", bus.mem_address, (g < 0) ? 32'd0 : {25'd0, ga});
    chk("mem_wdata", bus.mem_wdata, (g < 0) ? 32'd0 : gd);
    chk("rsp_valid", {30'd0, bus.rsp_valid}, rst ? {30'd0, expRspV} : 32'd0);
    chk("rsp_data", bus.rsp_data, expRspD);
    if (!rst) modelReset();
    else begin
      expRspV = 2'b00;
      if (g >= 0) begin
        if (w[g]) refMem[ga] = gd;
        else begin
          expRspV = 2'b01 << g;
          expRspD = refMem[ga];
        end
        run = (g == owner) ? run + 1 : 1;
        owner = g; lastOwn = g;
      end else begin
        owner = -1; run = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    logic [6:0] ra0, ra1;
    for (int i = 0; i < 128; i++) begin mem[i] = 32'd0; refMem[i] = 32'd0; end
    reset_n = 1'b0;
    bus.req_valid = 2'b00; bus.req_write = 2'b00;
    bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_wdata0 = '0; bus.req_wdata1 = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;

    // Reset held with both ports requesting.
    repeat (2) cyc(1'b0, 2'b11, 2'b11, 7'd1, 7'd2, 32'h1, 32'h2);

    // Single write then read by port 0.
    cyc(1'b1, 2'b01, 2'b01, 7'd5, 7'd0, 32'hDEADBEEF, 32'd0);
    cyc(1'b1, 2'b01, 2'b00, 7'd5, 7'd0, 32'd0, 32'd0);
    chk("rd_dead_data", bus.rsp_data, 32'hDEADBEEF);
    chk("rd_dead_valid", {30'd0, bus.rsp_valid}, 32'd1);
    cyc(1'b1, 2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);

    // Tie from reset: 0000 1111 0000.
    cyc(1'b0, 2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 2'b11, 2'b00, 7'(i), 7'(i + 64), 32'd0, 32'd0);
      chk("tie_pattern", {30'd0, seenReady}, ((i / 4) % 2) ? 32'd2 : 32'd1);
    end

    // Burst cap: port 1 joins at cycle 2, gets in after 4 port-0 grants.
    cyc(1'b0, 2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);
    n0 = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, (i < 2) ? 2'b01 : 2'b11, 2'b11, 7'(i), 7'(i + 32), 32'(i), 32'(i + 100));
      if (seenReady == 2'b10) break;
      if (seenReady == 2'b01) n0++;
    end
    chk("burst_cap", 32'(n0), 32'd4);
    for (int i = 0; i < 20; i++) cyc(1'b1, 2'b01, 2'b00, 7'(i), 7'd0, 32'd0, 32'd0);

    // Cross-port RAW at the top address.
    cyc(1'b1, 2'b10, 2'b10, 7'd0, 7'd127, 32'd0, 32'h12345678);
    cyc(1'b1, 2'b01, 2'b00, 7'd127, 7'd0, 32'd0, 32'd0);
    chk("raw_data", bus.rsp_data, 32'h12345678);
    chk("raw_valid", {30'd0, bus.rsp_valid}, 32'd1);
    cyc(1'b1, 2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);

    // Reset right after a granted read drops the response.
    cyc(1'b1, 2'b01, 2'b00, 7'd127, 7'd0, 32'd0, 32'd0);
    cyc(1'b0, 2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);
    chk("rst_drop_data", bus.rsp_data, 32'd0);
    cyc(1'b1, 2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);

    // Random traffic with occasional resets; small address window to force hits.
    for (int i = 0; i < 600; i++) begin
      ra0 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(120, 127));
      ra1 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(120, 127));
      cyc(($urandom_range(0, 49) != 0), 2'($urandom), 2'($urandom), ra0, ra1, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
